fpu_result_collector: RTL

FPU_RESULT_COLLECTOR -- requirements
Module: fpu_result_collector

---
 rtl/fpu_result_collector.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fpu_result_collector.sv
// Captures FPU results LATENCY cycles after issue into a ready/valid FIFO with drop/count stats.
// Define FPU_COLLECTOR_EXC_CNT_EN to build the exception counter; otherwise exc_count reads 0.
module fpu_result_collector #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] out,
  input  logic        inf,
  input  logic        snan,
  input  logic        qnan,
  input  logic        ine,
  input  logic        overflow,
  input  logic        underflow,
  input  logic        zero,
  input  logic        div_by_zero,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic [7:0]  rd_flags,
  output logic [2:0]  rd_op,
  output logic [6:0]  level,
  output logic        drop,
  output logic [31:0] result_count,
  output logic [15:0] exc_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [2:0]         op_q [LATENCY];
  logic [2:0]         op_d [LATENCY];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0]         level_q, level_d;
  logic               drop_q, drop_d;
  logic [31:0]        res_cnt_q, res_cnt_d;
  logic [74:0]        mem [DEPTH];

  logic       strobe, full, empty, pop, push;
  logic [7:0] cap_flags;
  logic [2:0] cap_op;

  always_comb begin
    vld_d    = vld_q;
    op_d     = op_q;
    vld_d[0] = issue;
    op_d[0]  = fpu_op;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      op_d[i]  = op_q[i-1];
    end
  end

  assign strobe    = vld_q[LATENCY-1];
  assign cap_op    = op_q[LATENCY-1];
  assign cap_flags = {div_by_zero, zero, underflow, overflow, ine, qnan, snan, inf};

  assign full  = (level_q == 7'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && rd_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push  = strobe && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    drop_d    = drop_q;
    res_cnt_d = res_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 7'd1;
    else if (pop && !push) level_d = level_q - 7'd1;
    if (strobe && !push) drop_d = 1'b1;
    if (strobe && res_cnt_q != '1) res_cnt_d = res_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      drop_q    <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      vld_q     <= vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      drop_q    <= drop_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {cap_op, cap_flags, out};
  end

`ifdef FPU_COLLECTOR_EXC_CNT_EN
  logic [15:0] exc_cnt_q, exc_cnt_d;
  logic        exc_hit;

  assign exc_hit = snan | qnan | overflow | underflow | div_by_zero;

  always_comb begin
    exc_cnt_d = exc_cnt_q;
    if (strobe && exc_hit && exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) exc_cnt_q <= '0;
    else     exc_cnt_q <= exc_cnt_d;
  end

  assign exc_count = exc_cnt_q;
`else
  assign exc_count = '0;
`endif

  assign rd_valid                   = !empty;
  assign {rd_op, rd_flags, rd_data} = mem[rd_ptr_q];
  assign level                      = level_q;
  assign drop                       = drop_q;
  assign result_count               = res_cnt_q;

endmodule
